// File: rtl/ysyx_22050518_mem_pkg.sv
// Shared types and helpers for the memory stage: FSM states, load/store
// size encodings, and the latched descriptor of an in-flight access.
package ysyx_22050518_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_e;

  // func3 encodings for loads; stores only use the low two bits (size)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // What must survive from accept until the response comes back
  typedef struct packed {
    logic       is_load;
    logic [2:0] func3;
    logic [2:0] off;
    logic [4:0] rd_addr;
    logic       rd_w;
  } mem_op_t;

  // Byte-strobe pattern for an access of 1/2/4/8 bytes at offset 0
  function automatic logic [7:0] sizemask(input logic [1:0] size);
    case (size)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22050518_lsu_align.sv
// Combinational lane steering: positions store data/strobes inside the
// doubleword, and pulls a load value out of the returned doubleword.
module ysyx_22050518_lsu_align
  import ysyx_22050518_mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] st_data_i,
  input  logic [2:0]      st_off_i,
  input  logic [1:0]      st_size_i,
  output logic [XLEN-1:0] st_wdata_o,
  output logic [7:0]      st_wmask_o,
  input  logic [XLEN-1:0] ld_rdata_i,
  input  logic [2:0]      ld_off_i,
  input  logic [2:0]      ld_func3_i,
  output logic [XLEN-1:0] ld_data_o
);

  logic [XLEN-1:0] ld_sh;

  // Store: shift data and strobes to the byte lane; strobes past byte 7 drop off
  always_comb begin
    st_wdata_o = st_data_i << {st_off_i, 3'b000};
    st_wmask_o = sizemask(st_size_i) << st_off_i;
  end

  // Load: bring the addressed byte to lane 0, then size and extend
  always_comb begin
    // NOTE: outputs get a default before the case so an uncovered branch cannot infer a latch.
    ld_data_o = '0;
    ld_sh     = ld_rdata_i >> {ld_off_i, 3'b000};
    case (ld_func3_i)
      F3_LB:   ld_data_o = {{(XLEN-8){ld_sh[7]}}, ld_sh[7:0]};
      F3_LBU:  ld_data_o = {{(XLEN-8){1'b0}}, ld_sh[7:0]};
      F3_LH:   ld_data_o = {{(XLEN-16){ld_sh[15]}}, ld_sh[15:0]};
      F3_LHU:  ld_data_o = {{(XLEN-16){1'b0}}, ld_sh[15:0]};
      F3_LW:   ld_data_o = {{(XLEN-32){ld_sh[31]}}, ld_sh[31:0]};
      F3_LWU:  ld_data_o = {{(XLEN-32){1'b0}}, ld_sh[31:0]};
      F3_LD:   ld_data_o = ld_sh;
      default: ld_data_o = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_22050518_mem_stage.sv
// Memory pipeline stage: passes ALU results through in one cycle, or runs a
// single request/response on the data-memory port for loads and stores.
module ysyx_22050518_mem_stage
  import ysyx_22050518_mem_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int AW   = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_rd,
  input  logic [4:0]      in_rd_addr,
  input  logic            in_rd_w,
  input  logic            in_mem_rd,
  input  logic            in_mem_wr,
  input  logic [2:0]      in_func3,
  input  logic [XLEN-1:0] in_store_data,
  output logic            pipe4_allowin,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic            dmem_req_wr,
  output logic [AW-1:0]   dmem_req_addr,
  output logic [XLEN-1:0] dmem_req_wdata,
  output logic [7:0]      dmem_req_wmask,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rsp_rdata,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_rd,
  output logic [4:0]      wb_rd_addr,
  output logic            wb_rd_w,
  input  logic            wb_allowin,
  output logic [XLEN-1:0] fwd_rd,
  output logic            fwd_valid
);

  state_e          state_q, state_d;
  mem_op_t         op_q, op_d;
  logic            wb_valid_q, wb_valid_d;
  logic [XLEN-1:0] wb_rd_q, wb_rd_d;
  logic [4:0]      wb_rd_addr_q, wb_rd_addr_d;
  logic            wb_rd_w_q, wb_rd_w_d;
  logic            req_valid_q, req_valid_d;
  logic            req_wr_q, req_wr_d;
  logic [AW-1:0]   req_addr_q, req_addr_d;
  logic [XLEN-1:0] req_wdata_q, req_wdata_d;
  logic [7:0]      req_wmask_q, req_wmask_d;

  logic [XLEN-1:0] st_wdata, ld_data;
  logic [7:0]      st_wmask;
  logic            in_is_mem;

  // Store lanes come from the incoming op; load extraction from the latched op
  ysyx_22050518_lsu_align #(.XLEN(XLEN)) u_align (
    .st_data_i  (in_store_data),
    .st_off_i   (in_rd[2:0]),
    .st_size_i  (in_func3[1:0]),
    .st_wdata_o (st_wdata),
    .st_wmask_o (st_wmask),
    .ld_rdata_i (dmem_rsp_rdata),
    .ld_off_i   (op_q.off),
    .ld_func3_i (op_q.func3),
    .ld_data_o  (ld_data)
  );

  assign in_is_mem     = in_mem_rd | in_mem_wr;
  assign pipe4_allowin = (state_q == IDLE) && (!wb_valid_q || wb_allowin);

  // Next-state and datapath updates for the accept / request / response flow
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    wb_valid_d   = wb_valid_q;
    wb_rd_d      = wb_rd_q;
    wb_rd_addr_d = wb_rd_addr_q;
    wb_rd_w_d    = wb_rd_w_q;
    req_valid_d  = req_valid_q;
    req_wr_d     = req_wr_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    req_wmask_d  = req_wmask_q;
    case (state_q)
      IDLE: begin
        if (in_valid && pipe4_allowin) begin
          if (in_is_mem) begin
            op_d.is_load = in_mem_rd;
            op_d.func3   = in_func3;
            op_d.off     = in_rd[2:0];
            op_d.rd_addr = in_rd_addr;
            op_d.rd_w    = in_rd_w && in_mem_rd && (in_rd_addr != 5'd0);
            // Old bundle has left (allow-in held), so the slot idles until the response
            wb_valid_d   = 1'b0;
            req_valid_d  = 1'b1;
            req_wr_d     = in_mem_wr;
            req_addr_d   = AW'(in_rd);
            req_wdata_d  = in_mem_wr ? st_wdata : '0;
            req_wmask_d  = in_mem_wr ? st_wmask : 8'h00;
            state_d      = REQ;
          end else begin
            wb_valid_d   = 1'b1;
            wb_rd_d      = in_rd;
            wb_rd_addr_d = in_rd_addr;
            wb_rd_w_d    = in_rd_w && (in_rd_addr != 5'd0);
          end
        end else if (wb_allowin) begin
          wb_valid_d = 1'b0;
        end
      end
      REQ: begin
        if (dmem_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (dmem_rsp_valid) begin
          wb_valid_d   = 1'b1;
          wb_rd_addr_d = op_q.rd_addr;
          wb_rd_w_d    = op_q.rd_w;
          if (op_q.is_load) wb_rd_d = ld_data;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= '0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_rd_addr_q <= 5'd0;
      wb_rd_w_q    <= 1'b0;
      req_valid_q  <= 1'b0;
      req_wr_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      req_wmask_q  <= 8'h00;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values together.
      state_q      <= state_d;
      op_q         <= op_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_rd_addr_q <= wb_rd_addr_d;
      wb_rd_w_q    <= wb_rd_w_d;
      req_valid_q  <= req_valid_d;
      req_wr_q     <= req_wr_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      req_wmask_q  <= req_wmask_d;
    end
  end

  assign wb_valid       = wb_valid_q;
  assign wb_rd          = wb_rd_q;
  assign wb_rd_addr     = wb_rd_addr_q;
  assign wb_rd_w        = wb_rd_w_q;
  assign fwd_rd         = wb_rd_q;
  assign fwd_valid      = wb_valid_q & wb_rd_w_q;
  assign dmem_req_valid = req_valid_q;
  assign dmem_req_wr    = req_wr_q;
  assign dmem_req_addr  = req_addr_q;
  assign dmem_req_wdata = req_wdata_q;
  assign dmem_req_wmask = req_wmask_q;

endmodule

// File: tb/tb_ysyx_22050518_mem_stage.sv
// Bench for the memory stage: directed cases pinned with literal values,
// then randomized traffic checked every cycle against a transaction model.
module tb_ysyx_22050518_mem_stage;

  logic        clk, rst;
  logic        in_valid, in_rd_w, in_mem_rd, in_mem_wr;
  logic [63:0] in_rd, in_store_data;
  logic [4:0]  in_rd_addr;
  logic [2:0]  in_func3;
  logic        pipe4_allowin;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_wr;
  logic [63:0] dmem_req_addr, dmem_req_wdata;
  logic [7:0]  dmem_req_wmask;
  logic        dmem_rsp_valid;
  logic [63:0] dmem_rsp_rdata;
  logic        wb_valid, wb_rd_w, wb_allowin, fwd_valid;
  logic [63:0] wb_rd, fwd_rd;
  logic [4:0]  wb_rd_addr;

  int n_checks = 0;
  int n_pass   = 0;

  ysyx_22050518_mem_stage #(.XLEN(64), .AW(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_rd(in_rd), .in_rd_addr(in_rd_addr), .in_rd_w(in_rd_w),
    .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr), .in_func3(in_func3),
    .in_store_data(in_store_data), .pipe4_allowin(pipe4_allowin),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_wr(dmem_req_wr), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_wmask(dmem_req_wmask),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_rd_addr(wb_rd_addr), .wb_rd_w(wb_rd_w),
    .wb_allowin(wb_allowin), .fwd_rd(fwd_rd), .fwd_valid(fwd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Load value from the spec rule: shift, keep 1/2/4/8 bytes, extend.
  function automatic bit [63:0] exp_load(bit [63:0] rdata, bit [2:0] off, bit [2:0] f3);
    int      nbytes;
    bit [63:0] v, m;
    if (f3 == 3'b111) return 64'd0;
    nbytes = 1 << f3[1:0];
    v = rdata >> (8 * off);
    if (nbytes == 8) return v;
    m = (64'd1 << (8 * nbytes)) - 64'd1;
    v = v & m;
    if (!f3[2] && v[8*nbytes-1]) v = v | ~m;
    return v;
  endfunction

  bit        m_req_pend, m_rsp_wait;
  bit        m_wb_valid, m_wb_rd_w, m_wb_store;
  bit [63:0] m_wb_rd;
  bit [4:0]  m_wb_rd_addr;
  bit        m_req_wr;
  bit [63:0] m_req_addr, m_req_wdata;
  bit [7:0]  m_req_wmask;
  bit        m_op_load, m_op_rd_w;
  bit [2:0]  m_op_off, m_op_f3;
  bit [4:0]  m_op_rd_addr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_req_pend = 0; m_rsp_wait = 0; m_wb_valid = 0; m_wb_rd_w = 0; m_wb_store = 0;
      m_wb_rd = 0; m_wb_rd_addr = 0; m_req_wr = 0; m_req_addr = 0; m_req_wdata = 0;
      m_req_wmask = 0;
    end else if (m_rsp_wait) begin
      if (dmem_rsp_valid) begin
        m_rsp_wait   = 0;
        m_wb_valid   = 1;
        m_wb_store   = !m_op_load;
        m_wb_rd_addr = m_op_rd_addr;
        m_wb_rd_w    = m_op_load && m_op_rd_w && (m_op_rd_addr != 0);
        if (m_op_load) m_wb_rd = exp_load(dmem_rsp_rdata, m_op_off, m_op_f3);
      end
    end else if (m_req_pend) begin
      if (dmem_req_ready) begin
        m_req_pend = 0;
        m_rsp_wait = 1;
      end
    end else if (in_valid && (!m_wb_valid || wb_allowin)) begin
      if (in_mem_rd || in_mem_wr) begin
        int sm;
        sm = (1 << (1 << in_func3[1:0])) - 1;
        m_req_pend   = 1;
        m_wb_valid   = 0;
        m_op_load    = in_mem_rd;
        m_op_rd_w    = in_rd_w;
        m_op_rd_addr = in_rd_addr;
        m_op_off     = in_rd[2:0];
        m_op_f3      = in_func3;
        m_req_wr     = in_mem_wr;
        m_req_addr   = in_rd;
        m_req_wdata  = in_mem_wr ? (in_store_data << (8 * in_rd[2:0])) : 64'd0;
        m_req_wmask  = in_mem_wr ? 8'((sm << in_rd[2:0]) & 255) : 8'd0;
      end else begin
        m_wb_valid   = 1;
        m_wb_store   = 0;
        m_wb_rd      = in_rd;
        m_wb_rd_addr = in_rd_addr;
        m_wb_rd_w    = in_rd_w && (in_rd_addr != 0);
      end
    end else if (wb_allowin) begin
      m_wb_valid = 0;
    end
  end

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    bit exp_allow;
    exp_allow = !m_req_pend && !m_rsp_wait && (!m_wb_valid || wb_allowin);
    check("allowin", {63'd0, pipe4_allowin}, {63'd0, exp_allow});
    check("wb_valid", {63'd0, wb_valid}, {63'd0, m_wb_valid});
    check("fwd_valid", {63'd0, fwd_valid}, {63'd0, m_wb_valid && m_wb_rd_w});
    check("req_valid", {63'd0, dmem_req_valid}, {63'd0, m_req_pend});
    if (m_wb_valid) begin
      check("wb_rd_addr", {59'd0, wb_rd_addr}, {59'd0, m_wb_rd_addr});
      check("wb_rd_w", {63'd0, wb_rd_w}, {63'd0, m_wb_rd_w});
      if (!m_wb_store) begin
        check("wb_rd", wb_rd, m_wb_rd);
        check("fwd_rd", fwd_rd, m_wb_rd);
      end
    end
    if (m_req_pend) begin
      check("req_wr", {63'd0, dmem_req_wr}, {63'd0, m_req_wr});
      check("req_addr", dmem_req_addr, m_req_addr);
      check("req_wdata", dmem_req_wdata, m_req_wdata);
      check("req_wmask", {56'd0, dmem_req_wmask}, {56'd0, m_req_wmask});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input bit rd, input bit wr, input logic [63:0] a, input logic [4:0] ra,
                          input bit rw, input logic [2:0] f3, input logic [63:0] sd);
    in_valid = 1; in_mem_rd = rd; in_mem_wr = wr; in_rd = a; in_rd_addr = ra;
    in_rd_w = rw; in_func3 = f3; in_store_data = sd;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wb_valid"}, {63'd0, wb_valid}, 64'd0);
    check({tag, "_wb_rd"}, wb_rd, 64'd0);
    check({tag, "_wb_rd_addr"}, {59'd0, wb_rd_addr}, 64'd0);
    check({tag, "_wb_rd_w"}, {63'd0, wb_rd_w}, 64'd0);
    check({tag, "_fwd_valid"}, {63'd0, fwd_valid}, 64'd0);
    check({tag, "_req_valid"}, {63'd0, dmem_req_valid}, 64'd0);
    check({tag, "_req_wr"}, {63'd0, dmem_req_wr}, 64'd0);
    check({tag, "_req_addr"}, dmem_req_addr, 64'd0);
    check({tag, "_req_wdata"}, dmem_req_wdata, 64'd0);
    check({tag, "_req_wmask"}, {56'd0, dmem_req_wmask}, 64'd0);
  endtask

  task automatic do_load(input string name, input logic [63:0] a, input logic [2:0] f3,
                         input logic [63:0] rdata, input logic [63:0] exp);
    drive_op(1, 0, a, 5'd7, 1, f3, 64'd0);
    dmem_req_ready = 0;
    cyc();
    in_valid = 0; dmem_req_ready = 1;
    @(negedge clk);
    check({name, "_addr"}, dmem_req_addr, a);
    cyc();
    dmem_req_ready = 0; dmem_rsp_valid = 1; dmem_rsp_rdata = rdata;
    cyc();
    dmem_rsp_valid = 0;
    @(negedge clk);
    check({name, "_valid"}, {63'd0, wb_valid}, 64'd1);
    check(name, wb_rd, exp);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    bit acc, fire, gen;
    int rsp_cnt, kind;
    rst = 0; in_valid = 0; in_rd = 0; in_rd_addr = 0; in_rd_w = 0; in_mem_rd = 0;
    in_mem_wr = 0; in_func3 = 0; in_store_data = 0; wb_allowin = 1;
    dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rsp_rdata = 0;
    #2 rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    check("reset_allowin", {63'd0, pipe4_allowin}, 64'd1);
    cyc();
    rst = 0;

    // Non-memory pass-through, latency 1
    drive_op(0, 0, 64'h1234, 5'd5, 1, 3'd0, 64'd0);
    cyc();
    in_valid = 0;
    @(negedge clk);
    check("alu_wb_valid", {63'd0, wb_valid}, 64'd1);
    check("alu_wb_rd", wb_rd, 64'h1234);
    check("alu_rd_addr", {59'd0, wb_rd_addr}, 64'd5);
    check("alu_fwd_valid", {63'd0, fwd_valid}, 64'd1);
    check("alu_fwd_rd", fwd_rd, 64'h1234);
    cyc();

    // Load extraction
    do_load("lb", 64'h1003, 3'b000, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    do_load("lbu", 64'h1003, 3'b100, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);
    do_load("lh", 64'h1006, 3'b001, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001);
    do_load("f3_111", 64'h1000, 3'b111, 64'hDEAD_BEEF_DEAD_BEEF, 64'd0);

    // Halfword store at offset 6
    drive_op(0, 1, 64'h2006, 5'd9, 1, 3'b001, 64'hBEEF);
    cyc();
    in_valid = 0; dmem_req_ready = 1;
    @(negedge clk);
    check("sh_wmask", {56'd0, dmem_req_wmask}, 64'hC0);
    check("sh_wdata", dmem_req_wdata, 64'hBEEF_0000_0000_0000);
    check("sh_wr", {63'd0, dmem_req_wr}, 64'd1);
    cyc();
    dmem_req_ready = 0; dmem_rsp_valid = 1;
    cyc();
    dmem_rsp_valid = 0;
    @(negedge clk);
    check("sh_wb_valid", {63'd0, wb_valid}, 64'd1);
    check("sh_wb_rd_w", {63'd0, wb_rd_w}, 64'd0);
    check("sh_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    cyc();

    // Request stall: ready low 3 cycles, word store crossing the doubleword
    drive_op(0, 1, 64'h3005, 5'd3, 1, 3'b010, 64'h1122_3344);
    cyc();
    in_valid = 0; dmem_req_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", {63'd0, dmem_req_valid}, 64'd1);
      check("stall_addr", dmem_req_addr, 64'h3005);
      check("stall_wdata", dmem_req_wdata, 64'h2233_4400_0000_0000);
      check("stall_wmask", {56'd0, dmem_req_wmask}, 64'hE0);
      check("stall_allowin", {63'd0, pipe4_allowin}, 64'd0);
      cyc();
    end
    dmem_req_ready = 1;
    @(negedge clk);
    check("stall_c4_valid", {63'd0, dmem_req_valid}, 64'd1);
    cyc();
    dmem_req_ready = 0;
    @(negedge clk);
    check("stall_accepted", {63'd0, dmem_req_valid}, 64'd0);
    check("stall_rsp_allowin", {63'd0, pipe4_allowin}, 64'd0);
    cyc();
    dmem_rsp_valid = 1;
    cyc();
    dmem_rsp_valid = 0;
    @(negedge clk);
    check("stall_done", {63'd0, wb_valid}, 64'd1);
    cyc();

    // Back-pressure, then back-to-back accept
    wb_allowin = 0;
    drive_op(0, 0, 64'hAAAA, 5'd10, 1, 3'd0, 64'd0);
    cyc();
    drive_op(0, 0, 64'hBBBB, 5'd11, 1, 3'd0, 64'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bp_valid", {63'd0, wb_valid}, 64'd1);
      check("bp_hold", wb_rd, 64'hAAAA);
      check("bp_allowin", {63'd0, pipe4_allowin}, 64'd0);
      cyc();
    end
    wb_allowin = 1;
    @(negedge clk);
    check("b2b_allowin", {63'd0, pipe4_allowin}, 64'd1);
    cyc();
    in_valid = 0;
    @(negedge clk);
    check("b2b_valid", {63'd0, wb_valid}, 64'd1);
    check("b2b_rd", wb_rd, 64'hBBBB);
    check("b2b_rd_addr", {59'd0, wb_rd_addr}, 64'd11);
    cyc();

    // Reset while waiting for a response, then a stray response
    drive_op(1, 0, 64'h4000, 5'd12, 1, 3'b011, 64'd0);
    dmem_req_ready = 1;
    cyc();
    in_valid = 0;
    cyc();
    dmem_req_ready = 0;
    @(negedge clk);
    check("rsp_wait_req", {63'd0, dmem_req_valid}, 64'd0);
    check("rsp_wait_wb", {63'd0, wb_valid}, 64'd0);
    @(posedge clk);
    #1 rst = 1;
    #1 check_zero("mid_reset");
    cyc();
    rst = 0;
    cyc();
    dmem_rsp_valid = 1; dmem_rsp_rdata = 64'h5555_5555_5555_5555;
    cyc();
    dmem_rsp_valid = 0;
    @(negedge clk);
    check("stray_rsp_wb", {63'd0, wb_valid}, 64'd0);
    check("stray_rsp_allowin", {63'd0, pipe4_allowin}, 64'd1);
    cyc();

    // Randomized traffic with a random-latency memory
    rsp_cnt = 0;
    for (int c = 0; c < 1530; c++) begin
      gen = (c < 1500);
      @(negedge clk);
      acc  = in_valid && pipe4_allowin;
      fire = dmem_req_valid && dmem_req_ready;
      cyc();
      dmem_rsp_valid = 0;
      if (fire) rsp_cnt = $urandom_range(1, 3);
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          dmem_rsp_valid = 1;
          dmem_rsp_rdata = {$urandom, $urandom};
        end
      end
      dmem_req_ready = ($urandom_range(0, 1) == 1);
      if (acc || !in_valid) begin
        if (gen && $urandom_range(0, 9) < 7) begin
          kind = $urandom_range(0, 3);
          in_valid      = 1;
          in_rd         = {$urandom, $urandom};
          in_rd_addr    = 5'($urandom_range(0, 31));
          in_rd_w       = 1'($urandom_range(0, 1));
          in_mem_rd     = (kind == 2);
          in_mem_wr     = (kind == 3);
          in_func3      = 3'($urandom_range(0, 7));
          if (kind == 3) in_func3[2] = 1'b0;
          in_store_data = {$urandom, $urandom};
        end else begin
          in_valid = 0;
        end
      end
      wb_allowin = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
